// File: rtl/msu_sq_sched_if.sv
// Host-side job request and result stream of the squaring-unit scheduler.
// Signal names match the scheduler's original flat ports.
interface msu_sq_sched_if #(
    parameter int unsigned MOD_LEN  = 1024,
    parameter int unsigned T_LEN    = 64,
    parameter int unsigned CK_LEN   = 32,
    parameter int unsigned WDOG_LEN = 32
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [T_LEN-1:0]    cfg_t_start;
    logic [T_LEN-1:0]    cfg_t_final;
    logic [MOD_LEN-1:0]  cfg_sq_in;
    logic [CK_LEN-1:0]   cfg_ck_int;
    logic [WDOG_LEN-1:0] cfg_wdog;

    logic                res_valid;
    logic                res_ready;
    logic [T_LEN-1:0]    res_t;
    logic [MOD_LEN-1:0]  res_sq;
    logic                res_last;

    modport master (
        output cfg_valid, cfg_t_start, cfg_t_final, cfg_sq_in, cfg_ck_int, cfg_wdog,
        input  cfg_ready,
        input  res_valid, res_t, res_sq, res_last,
        output res_ready
    );

    modport slave (
        input  cfg_valid, cfg_t_start, cfg_t_final, cfg_sq_in, cfg_ck_int, cfg_wdog,
        output cfg_ready,
        output res_valid, res_t, res_sq, res_last,
        input  res_ready
    );
endinterface

// File: rtl/msu_sq_sched.sv
// Iteration scheduler for the modular squarer: flush/kick, iteration counting,
// periodic checkpoints and final result into a 2-entry FWFT result FIFO.
module msu_sq_sched #(
    parameter int unsigned MOD_LEN   = 1024,
    parameter int unsigned T_LEN     = 64,
    parameter int unsigned CK_LEN    = 32,
    parameter int unsigned WDOG_LEN  = 32,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    msu_sq_sched_if.slave      host,
    input  logic               abort,
    output logic               sq_reset,
    output logic               sq_valid_in,
    output logic [MOD_LEN-1:0] sq_data,
    input  logic               sq_valid_out,
    input  logic [MOD_LEN-1:0] sq_out,
    output logic               busy,
    output logic [T_LEN-1:0]   t_current,
    output logic               overrun,
    output logic               timeout,
    output logic               cfg_err
);
    localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_KICK, S_RUN, S_FINAL, S_ABORT} state_e;

    state_e              state_q, state_d;
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [T_LEN-1:0]    t_current_q, t_current_d;
    logic [T_LEN-1:0]    t_final_q, t_final_d;
    logic [CK_LEN-1:0]   ck_int_q, ck_int_d;
    logic [CK_LEN-1:0]   ck_cnt_q, ck_cnt_d;
    logic [WDOG_LEN-1:0] wdog_lim_q, wdog_lim_d;
    logic [WDOG_LEN-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [MOD_LEN-1:0]  sq_data_q, sq_data_d;
    logic [T_LEN-1:0]    fin_t_q, fin_t_d;
    logic [MOD_LEN-1:0]  fin_sq_q, fin_sq_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                cfg_err_q, cfg_err_d;

    logic [T_LEN-1:0]    mem_t_q    [2];
    logic [T_LEN-1:0]    mem_t_d    [2];
    logic [MOD_LEN-1:0]  mem_sq_q   [2];
    logic [MOD_LEN-1:0]  mem_sq_d   [2];
    logic                mem_last_q [2];
    logic                mem_last_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;

    logic                push, push_last, pop, can_push, flush_fifo;
    logic [T_LEN-1:0]    push_t, t_next;
    logic [MOD_LEN-1:0]  push_sq;
    logic [CK_LEN-1:0]   ck_next;
    logic [WDOG_LEN-1:0] wdog_next;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        t_current_d = t_current_q;
        t_final_d   = t_final_q;
        ck_int_d    = ck_int_q;
        ck_cnt_d    = ck_cnt_q;
        wdog_lim_d  = wdog_lim_q;
        wdog_cnt_d  = wdog_cnt_q;
        sq_data_d   = sq_data_q;
        fin_t_d     = fin_t_q;
        fin_sq_d    = fin_sq_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        cfg_err_d   = cfg_err_q;
        push        = 1'b0;
        push_t      = '0;
        push_sq     = '0;
        push_last   = 1'b0;
        flush_fifo  = 1'b0;
        pop         = (fifo_cnt_q != 2'd0) && host.res_ready;
        can_push    = (fifo_cnt_q != 2'd2) || pop;
        t_next      = t_current_q + T_LEN'(1);
        ck_next     = ck_cnt_q + CK_LEN'(1);
        wdog_next   = wdog_cnt_q + WDOG_LEN'(1);

        case (state_q)
            S_IDLE: begin
                if (host.cfg_valid) begin
                    overrun_d   = 1'b0;
                    timeout_d   = 1'b0;
                    cfg_err_d   = 1'b0;
                    t_current_d = host.cfg_t_start;
                    t_final_d   = host.cfg_t_final;
                    ck_int_d    = host.cfg_ck_int;
                    wdog_lim_d  = host.cfg_wdog;
                    sq_data_d   = host.cfg_sq_in;
                    flush_cnt_d = '0;
                    if (host.cfg_t_final < host.cfg_t_start) begin
                        cfg_err_d = 1'b1;
                    end else if (host.cfg_t_final == host.cfg_t_start) begin
                        fin_t_d  = host.cfg_t_start;
                        fin_sq_d = host.cfg_sq_in;
                        state_d  = S_FINAL;
                    end else begin
                        state_d  = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (abort) state_d = S_ABORT;
                else if (flush_cnt_q == FC_W'(FLUSH_CYC - 1)) state_d = S_KICK;
                else flush_cnt_d = flush_cnt_q + FC_W'(1);
            end
            S_KICK: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    ck_cnt_d   = '0;
                    wdog_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (sq_valid_out) begin
                    t_current_d = t_next;
                    wdog_cnt_d  = '0;
                    if (t_next == t_final_q) begin
                        // With room, the final entry goes straight into the FIFO so
                        // res_valid follows the last pulse by one cycle; FINAL only holds it.
                        if (can_push) begin
                            push      = 1'b1;
                            push_t    = t_next;
                            push_sq   = sq_out;
                            push_last = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            fin_t_d  = t_next;
                            fin_sq_d = sq_out;
                            state_d  = S_FINAL;
                        end
                    end else if ((ck_int_q != '0) && (ck_next == ck_int_q)) begin
                        ck_cnt_d = '0;
                        if (can_push) begin
                            push    = 1'b1;
                            push_t  = t_next;
                            push_sq = sq_out;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        ck_cnt_d = ck_next;
                    end
                end else begin
                    wdog_cnt_d = wdog_next;
                    if ((wdog_lim_q != '0) && (wdog_next == wdog_lim_q)) begin
                        timeout_d = 1'b1;
                        state_d   = S_ABORT;
                    end
                end
            end
            S_FINAL: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (can_push) begin
                    push      = 1'b1;
                    push_t    = fin_t_q;
                    push_sq   = fin_sq_q;
                    push_last = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ABORT: begin
                flush_fifo = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        mem_t_d    = mem_t_q;
        mem_sq_d   = mem_sq_q;
        mem_last_d = mem_last_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush_fifo) begin
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (pop) rd_ptr_d = ~rd_ptr_q;
            if (push) begin
                mem_t_d[wr_ptr_q]    = push_t;
                mem_sq_d[wr_ptr_q]   = push_sq;
                mem_last_d[wr_ptr_q] = push_last;
                wr_ptr_d             = ~wr_ptr_q;
            end
            fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            t_current_q <= '0;
            t_final_q   <= '0;
            ck_int_q    <= '0;
            ck_cnt_q    <= '0;
            wdog_lim_q  <= '0;
            wdog_cnt_q  <= '0;
            sq_data_q   <= '0;
            fin_t_q     <= '0;
            fin_sq_q    <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_t_q[i]    <= '0;
                mem_sq_q[i]   <= '0;
                mem_last_q[i] <= 1'b0;
            end
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            t_current_q <= t_current_d;
            t_final_q   <= t_final_d;
            ck_int_q    <= ck_int_d;
            ck_cnt_q    <= ck_cnt_d;
            wdog_lim_q  <= wdog_lim_d;
            wdog_cnt_q  <= wdog_cnt_d;
            sq_data_q   <= sq_data_d;
            fin_t_q     <= fin_t_d;
            fin_sq_q    <= fin_sq_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            cfg_err_q   <= cfg_err_d;
            mem_t_q     <= mem_t_d;
            mem_sq_q    <= mem_sq_d;
            mem_last_q  <= mem_last_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign host.cfg_ready = (state_q == S_IDLE);
    assign host.res_valid = (fifo_cnt_q != 2'd0);
    assign host.res_t     = mem_t_q[rd_ptr_q];
    assign host.res_sq    = mem_sq_q[rd_ptr_q];
    assign host.res_last  = mem_last_q[rd_ptr_q];
    assign sq_reset       = (state_q == S_IDLE) || (state_q == S_FLUSH) || (state_q == S_ABORT);
    assign sq_valid_in    = (state_q == S_KICK);
    assign sq_data        = sq_data_q;
    assign busy           = (state_q != S_IDLE);
    assign t_current      = t_current_q;
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;
    assign cfg_err        = cfg_err_q;
endmodule
